// File: rtl/sm_frame_accum_pkg.sv
// rtl/sm_frame_accum_pkg.sv - shared constants for the sign-magnitude frame accumulator
//   FSM state encoding (ACCUM, HOLD) and the default-width negative-zero code.
package sm_frame_accum_pkg;

  localparam int unsigned DEF_DATA_W = 8;

  localparam logic ACCUM = 1'b0;
  localparam logic HOLD  = 1'b1;

  localparam logic [DEF_DATA_W-1:0] NEG_ZERO = {1'b1, {(DEF_DATA_W-1){1'b0}}};

endpackage

// File: rtl/sm_frame_accum_if.sv
// rtl/sm_frame_accum_if.sv - sample input and frame result handshake bundle
//   in_valid/in_ready/in_data   : sign-magnitude sample stream into the block
//   out_valid/out_ready/out_sum/out_negz : frame result towards the consumer
//   master : producer of samples / consumer of results
//   slave  : the accumulator itself
interface sm_frame_accum_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 10
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_negz;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_negz
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_negz
  );

endinterface

// File: rtl/sm_frame_accum_sm_to_tc.sv
// rtl/sm_frame_accum_sm_to_tc.sv - combinational sign-magnitude to two's complement converter
//   in_data : sign-magnitude sample, MSB is the sign
//   value   : two's-complement value sign-extended to ACC_W
//   is_negz : sample is the negative-zero code
module sm_to_tc #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 10
) (
  input  logic [DATA_W-1:0] in_data,
  output logic [ACC_W-1:0]  value,
  output logic              is_negz
);

  logic             sign;
  logic [ACC_W-1:0] mag_ext;

  assign sign    = in_data[DATA_W-1];
  assign mag_ext = {{(ACC_W-DATA_W+1){1'b0}}, in_data[DATA_W-2:0]};

  // Negating the zero-extended magnitude at full accumulator width yields the
  // sign-extended result directly; negative zero naturally becomes 0.
  assign value   = sign ? (~mag_ext + ACC_W'(1)) : mag_ext;
  assign is_negz = sign && (in_data[DATA_W-2:0] == '0);

endmodule

// File: rtl/sm_frame_accum.sv
// rtl/sm_frame_accum.sv - accumulates frames of sign-magnitude samples into a signed sum
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous frame abort, drops partial frame, held result and any same-cycle sample
//   bus   : slave side of the sample/result handshake bundle
module sm_frame_accum
  import sm_frame_accum_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned ACC_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  sm_frame_accum_if.slave   bus
);

  localparam int unsigned CNT_W = (N_SAMPLES > 2) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  logic             state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negz_q, negz_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_negz_q, out_negz_d;

  logic [ACC_W-1:0] value;
  logic             is_negz;
  logic             accept;

  sm_to_tc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_sm_to_tc (
    .in_data (bus.in_data),
    .value   (value),
    .is_negz (is_negz)
  );

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_negz  = out_negz_q;

  assign accept = bus.in_valid && (state_q == ACCUM);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    negz_d     = negz_q;
    out_sum_d  = out_sum_q;
    out_negz_d = out_negz_q;

    if (clr) begin
      // Abort wins over everything, including a sample accepted this cycle.
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      negz_d  = 1'b0;
    end else if (state_q == ACCUM) begin
      if (accept) begin
        if (cnt_q == LAST) begin
          out_sum_d  = acc_q + value;
          out_negz_d = negz_q | is_negz;
          acc_d      = '0;
          cnt_d      = '0;
          negz_d     = 1'b0;
          state_d    = HOLD;
        end else begin
          acc_d  = acc_q + value;
          cnt_d  = cnt_q + CNT_W'(1);
          negz_d = negz_q | is_negz;
        end
      end
    end else begin
      if (bus.out_ready) begin
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      negz_q     <= 1'b0;
      out_sum_q  <= '0;
      out_negz_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      negz_q     <= negz_d;
      out_sum_q  <= out_sum_d;
      out_negz_q <= out_negz_d;
    end
  end

endmodule

// File: doc/sm_frame_accum.md
Name: sm_frame_accum

Overview:
Downstream consumer of the sign-magnitude to complement conversion stage. It accepts 8-bit sign-magnitude samples over a valid/ready handshake and converts each one to true two's complement (invert magnitude plus 1). It accumulates a frame of N_SAMPLES samples and presents the signed frame sum on a valid/ready output port. It also flags any negative-zero code (8'h80) seen in the frame.

Parameters:
DATA_W, 8, sample width in bits: 1 sign bit plus DATA_W-1 magnitude bits.
N_SAMPLES, 4, samples per frame; must be at least 2.
ACC_W, 10, width of the two's-complement accumulator and output; must be at least DATA_W + ceil(log2(N_SAMPLES)).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous frame abort, active high.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a sample.
in_data  input  DATA_W  sign-magnitude sample: bit[DATA_W-1] is the sign, the lower bits are the magnitude.
out_valid  output  1  out_sum and out_negz are valid.
out_ready  input  1  downstream accepts the result.
out_sum  output  ACC_W  two's-complement frame sum.
out_negz  output  1  at least one 8'h80 (negative zero) was seen in this frame.

Behaviour:
- Reset is asynchronous, active-low, and applied on the falling edge of rst_n:
  - state=ACCUM, acc=0, cnt=0, negz=0.
  - out_valid=0, out_sum=0, out_negz=0.
  - in_ready=1 once reset is released.
- Conversion (combinational):
  - sign=0: value = zero-extend(magnitude).
  - sign=1: value = ~zero-extend(magnitude) + 1, sign-extended to ACC_W.
  - Negative zero (sign=1, magnitude=0) converts to 0 and sets negz.
- The handshake accepts a sample when in_valid and in_ready are both high on a rising edge. in_data is sampled only on acceptance.
- ACCUM state:
  - in_ready=1 and out_valid=0.
  - On each accept with cnt < N_SAMPLES-1: acc += value and cnt++.
  - On the accept with cnt == N_SAMPLES-1:
    - out_sum <= acc + value, out_negz <= negz or this sample's negz.
    - acc, cnt and negz clear.
    - Move to HOLD.
  - out_valid rises on the cycle after the last accept (latency 1).
- HOLD state:
  - in_ready=0 and out_valid=1.
  - out_sum and out_negz stay stable until out_ready=1 on an edge.
  - When out_ready=1: out_valid=0 and return to ACCUM. A new sample can be accepted from the following cycle.
- Arithmetic: the maximum magnitude sum is N_SAMPLES*(2^(DATA_W-1)-1), which fits in ACC_W by the parameter rule. No saturation logic is needed.
- clr handling (synchronous, highest priority):
  - acc, cnt and negz clear.
  - out_valid=0 and state=ACCUM.
  - A sample presented in the same cycle as clr is dropped, even though in_ready is high.
  - A result held in HOLD is discarded.
- If in_valid drops mid-frame, the partial acc and cnt are held indefinitely.
- Reset mid-frame or in HOLD returns everything to the reset values. Partial frames are lost.
- Exactly one frame result is produced per N_SAMPLES accepts. Results are never reordered or duplicated.

Decomposition:
- Shared package holds:
  - the state encoding: ACCUM=1'b0, HOLD=1'b1;
  - the NEG_ZERO constant (1 followed by DATA_W-1 zeros).
- Sub-module sm_to_tc is combinational:
  - inputs: in_data;
  - outputs: value[ACC_W-1:0] and is_negz;
  - it is unit-testable separately.
- The top level contains the FSM, counter, accumulator and output registers.

Test Plan:
- Reset, then feed 8'h05, 8'h03, 8'h01, 8'h02 -> out_valid one cycle after the 4th accept, out_sum=10'd11, out_negz=0.
- Feed 8'h85, 8'h03, 8'hFF, 8'h7F -> out_sum=10'h3FE (-2), out_negz=0.
- Feed 8'h80, 8'h00, 8'h80, 8'h01 -> out_sum=1, out_negz=1. The next frame of all 8'h01 gives out_negz=0.
- Feed 4x 8'hFF -> out_sum=10'h204 (-508). 4x 8'h7F -> 10'd508.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, out_sum stable, no sample consumed. After out_ready, the next frame is correct.
- Assert clr after 2 accepts, simultaneous with a 3rd valid sample -> that sample is dropped. The next 4 samples 8'h01 give out_sum=4. Async rst_n low during HOLD -> out_valid=0 immediately.
